// File: rtl/lsu_pkg.sv
// Shared size/state encodings and address helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_SIZE_B = 2'b00,
        LSU_SIZE_H = 2'b01,
        LSU_SIZE_W = 2'b10,
        LSU_SIZE_R = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'b00,
        LSU_RMW_RD = 2'b01,
        LSU_RMW_WR = 2'b10
    } lsu_state_e;

    // Reserved size 2'b11 behaves as a word.
    function automatic logic size_is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        if (size[1])
            return off != 2'b00;
        else if (size == LSU_SIZE_H)
            return off[0];
        else
            return 1'b0;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-addressed data memory port driven by the load/store unit.
interface load_store_unit_if;
    logic [31:0] Mem_Address;
    logic [31:0] Mem_Write_Data;
    logic        Mem_Read;
    logic        Mem_Write;
    logic [31:0] Mem_Read_Data;

    modport master (
        output Mem_Address,
        output Mem_Write_Data,
        output Mem_Read,
        output Mem_Write,
        input  Mem_Read_Data
    );

    modport slave (
        input  Mem_Address,
        input  Mem_Write_Data,
        input  Mem_Read,
        input  Mem_Write,
        output Mem_Read_Data
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extract/extend and store merge into a memory word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  byte_off,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign shamt   = {byte_off, 3'b000};
    assign shifted = mem_word >> shamt;
    assign lane_b  = shifted[7:0];
    // A half always uses lane Address[1]; Address[0] is ignored here.
    assign lane_h  = byte_off[1] ? mem_word[31:16] : mem_word[15:0];

    always_comb begin
        load_data  = mem_word;
        merge_data = wdata;
        case (lsu_size_e'(size))
            LSU_SIZE_B: begin
                load_data  = {{24{sign_ext & lane_b[7]}}, lane_b};
                merge_data = (mem_word & ~(32'h0000_00FF << shamt))
                           | ({24'h0, wdata[7:0]} << shamt);
            end
            LSU_SIZE_H: begin
                load_data  = {{16{sign_ext & lane_h[15]}}, lane_h};
                merge_data = byte_off[1] ? {wdata[15:0], mem_word[15:0]}
                                         : {mem_word[31:16], wdata[15:0]};
            end
            default: begin
                load_data  = mem_word;
                merge_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: single-cycle loads and word stores, 2-cycle RMW for sub-word stores.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of executing them.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                we,
    input  logic [1:0]          size,
    input  logic                sign_ext,
    input  logic [31:0]         Address,
    input  logic [31:0]         Write_Data,
    output logic [31:0]         Read_Data,
    output logic                stall,
    output logic                misalign_err,
    load_store_unit_if.master   mem
);

    lsu_state_e  state_q, state_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] addr_q,  addr_d;

    logic [31:0] load_data;
    logic [31:0] merge_data;
    logic        trap;
    logic        is_word;
    logic        sub_store;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = is_misaligned(size, Address[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign is_word   = size_is_word(size);
    assign sub_store = req & we & ~is_word & ~trap;

    lsu_lane_align u_align (
        .size       (size),
        .sign_ext   (sign_ext),
        .byte_off   (Address[1:0]),
        .mem_word   (mem.Mem_Read_Data),
        .wdata      (Write_Data),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LSU_IDLE;
            merge_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        merge_d = merge_q;
        addr_d  = addr_q;
        case (state_q)
            LSU_IDLE: begin
                if (sub_store) begin
                    state_d = LSU_RMW_RD;
                    merge_d = merge_data;
                    addr_d  = word_align(Address);
                end
            end
            LSU_RMW_RD: state_d = LSU_IDLE;
            default:    state_d = LSU_IDLE;
        endcase
    end

    // Outputs are gated by rst so nothing is driven while reset is held.
    always_comb begin
        Read_Data          = '0;
        stall              = 1'b0;
        misalign_err       = 1'b0;
        mem.Mem_Address    = '0;
        mem.Mem_Write_Data = '0;
        mem.Mem_Read       = 1'b0;
        mem.Mem_Write      = 1'b0;
        if (rst) begin
            case (state_q)
                LSU_IDLE: begin
                    if (req) begin
                        if (trap) begin
                            misalign_err = 1'b1;
                        end else begin
                            mem.Mem_Address = word_align(Address);
                            if (!we) begin
                                mem.Mem_Read = 1'b1;
                                Read_Data    = load_data;
                            end else if (is_word) begin
                                mem.Mem_Write      = 1'b1;
                                mem.Mem_Write_Data = Write_Data;
                            end else begin
                                mem.Mem_Read = 1'b1;
                                stall        = 1'b1;
                            end
                        end
                    end
                end
                LSU_RMW_RD: begin
                    mem.Mem_Write      = 1'b1;
                    mem.Mem_Address    = addr_q;
                    mem.Mem_Write_Data = merge_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

MEM-stage initiator that drives the word-addressed data memory on behalf of the pipeline. Converts byte/halfword/word loads and stores into word accesses: loads complete combinationally in one cycle, word stores write directly, and sub-word stores run a two-cycle read-modify-write while stalling the pipeline. Sits between the EX/MEM pipeline register and the data memory's `Address`/`Write_Data`/`Read_Data`/`DataMemory_Read`/`DataMemory_Write` port.

## Interface
Parameters:
- none; all widths fixed at 32 bits.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  1  MEM-stage instruction is a load or store.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  00 byte, 01 half, 10 word; 11 is reserved and treated as word.
- `sign_ext`  in  1  sign-extend sub-word loads; 0 = zero-extend.
- `Address`  in  32  byte address.
- `Write_Data`  in  32  store data, right-aligned.
- `Read_Data`  out  32  load result, extended; 0 when no load.
- `stall`  out  1  hold IF–MEM this cycle.
- `misalign_err`  out  1  misaligned access this cycle; see Configuration.
- `Mem_Address`  out  32  word address to memory, bits [1:0] = 00.
- `Mem_Write_Data`  out  32  word written to memory.
- `Mem_Read`  out  1  drives memory read enable.
- `Mem_Write`  out  1  drives memory write enable.
- `Mem_Read_Data`  in  32  memory read data; combinational, 0 when `Mem_Read` = 0.

## Operation
- Lanes are little-endian: byte k is `[8k+7:8k]`, selected by `Address[1:0]`. A half uses lane `Address[1]`.
- FSM states: IDLE, RMW_RD, RMW_WR.
- **IDLE, load** (`req & ~we`):
  - `Mem_Read` = 1 and `Mem_Address` = {Address[31:2], 2'b00}.
  - `Read_Data` = the selected lane, sign- or zero-extended; a word load passes through unchanged.
  - `stall` = 0; state stays IDLE.
- **IDLE, word store**: `Mem_Write` = 1 and `Mem_Write_Data` = `Write_Data`; `stall` = 0; state stays IDLE.
- **IDLE, sub-word store**:
  - `Mem_Read` = 1 and `stall` = 1.
  - At the clock edge, latch into `merge_q`: `Mem_Read_Data` with the target lane(s) replaced by `Write_Data[7:0]` or `Write_Data[15:0]`.
  - Latch the word address into `addr_q`; go to RMW_RD.
- **RMW_RD**: single cycle.
  - `Mem_Write` = 1, `Mem_Address` = `addr_q`, `Mem_Write_Data` = `merge_q`.
  - `stall` = 0, so the pipeline advances on this edge; next state is IDLE.
  - Inputs are ignored in this state, including the same `req` still being presented.
- **RMW_WR**: reserved encoding; falls to IDLE with all outputs inactive.
- Idle or non-request cycles: all memory outputs 0, `Read_Data` = 0, `stall` = 0, `misalign_err` = 0.
- Misaligned conditions: a half with `Address[0]` = 1, or a word with `Address[1:0]` ≠ 0. Handling depends on the macro in Configuration.
- Reset (`rst` = 0), including mid-RMW:
  - State goes to IDLE and `merge_q`/`addr_q` clear to 0.
  - No write is issued; every output reads 0.

## Timing
- Load: 0 cycles of added latency; the result is valid in the same cycle as `req`.
- Word store: the memory writes at the end of the request cycle.
- Sub-word store: exactly 1 stall cycle. The memory writes at the end of cycle 2; the pipeline advances at that same edge.
- Back-to-back: a new `req` is accepted in the cycle after RMW_RD.
  - A load immediately after a sub-word store to the same word sees the merged value, because the write lands on the preceding edge.
- `stall` is a Mealy output of the state and the inputs; no output is registered except through the state.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned request drives `misalign_err` = 1 for that cycle.
  - No memory access is made, `Read_Data` = 0, `stall` = 0, and there is no RMW.
- Not defined:
  - `misalign_err` is tied to 0.
  - Misaligned halves use lane `Address[1]`; misaligned words use the aligned-down word. Both proceed normally.

## Structure
- `lsu_pkg`:
  - size encodings `LSU_SIZE_B`, `LSU_SIZE_H`, `LSU_SIZE_W`;
  - state encodings `LSU_IDLE`, `LSU_RMW_RD`, `LSU_RMW_WR`.
- Sub-module `lsu_lane_align`, purely combinational, with two functions:
  - extract and extend for loads;
  - merge for stores.
- The FSM and registers live in `load_store_unit`.

## Test plan
- Memory word @0x40 = 0x8899AABB; load byte at 0x41, `sign_ext` = 1 -> `Read_Data` = 0xFFFFFFAA, `stall` = 0, `Mem_Address` = 0x40.
- Same word; load half at 0x42, `sign_ext` = 0 -> `Read_Data` = 0x00008899.
- Store byte 0x5C to 0x43 over 0x8899AABB -> cycle 1 `stall` = 1 with `Mem_Read` = 1; cycle 2 `Mem_Write` = 1 with `Mem_Write_Data` = 0x5C99AABB; word load at 0x40 in cycle 3 returns 0x5C99AABB.
- Word store 0x12345678 to 0x80 -> `Mem_Write` = 1 in the same cycle, `stall` = 0; the following load returns 0x12345678.
- Assert `rst` = 0 during RMW_RD of a half store to 0x44 -> no `Mem_Write`, `stall` = 0, and the word @0x44 is unchanged after reset.
- Word load at 0x46:
  - with `LSU_MISALIGN_TRAP_EN` -> `misalign_err` = 1, `Mem_Read` = 0, `Read_Data` = 0;
  - without it -> `Mem_Address` = 0x44 and the word @0x44 is returned.
